present80_round_ctrl: RTL



---
 rtl/present_pkg.sv | 27 ++
 rtl/Sbox.sv | 28 ++
 rtl/present80_round_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/present_pkg.sv
// Shared types and helpers for the iterative PRESENT-80 round controller.
package present_pkg;

    localparam int unsigned ROUNDS_C  = 31;
    localparam int unsigned NIBBLES_C = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_SUB,
        ST_PERM,
        ST_FINAL,
        ST_DONE
    } present_state_t;

    // Bit i moves to position 16*i mod 63; bit 63 is a fixed point.
    function automatic logic [63:0] p_layer(input logic [63:0] din);
        logic [63:0] dout;
        dout = '0;
        for (int i = 0; i < 63; i++) begin
            dout[(16 * i) % 63] = din[i];
        end
        dout[63] = din[63];
        return dout;
    endfunction

endpackage

// File: rtl/Sbox.sv
// PRESENT 4-bit substitution box, purely combinational.
module Sbox (
    input  logic [3:0] data_i,
    output logic [3:0] data_o
);

    always_comb begin
        case (data_i)
            4'h0: data_o = 4'hC;
            4'h1: data_o = 4'h5;
            4'h2: data_o = 4'h6;
            4'h3: data_o = 4'hB;
            4'h4: data_o = 4'h9;
            4'h5: data_o = 4'h0;
            4'h6: data_o = 4'hA;
            4'h7: data_o = 4'hD;
            4'h8: data_o = 4'h3;
            4'h9: data_o = 4'hE;
            4'hA: data_o = 4'hF;
            4'hB: data_o = 4'h8;
            4'hC: data_o = 4'h4;
            4'hD: data_o = 4'h7;
            4'hE: data_o = 4'h1;
            default: data_o = 4'h2;
        endcase
    end

endmodule

// File: rtl/present80_round_ctrl.sv
// Iterative PRESENT-80 encryptor: one shared S-box serves the 16 state nibbles
// and the key-schedule nibble, 18 cycles per round.
module present80_round_ctrl
    import present_pkg::*;
#(
    parameter int unsigned ROUNDS = ROUNDS_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] plaintext,
    input  logic [79:0] key,
    output logic        busy,
    output logic        done,
    output logic [63:0] ciphertext
);

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);
    localparam logic [3:0] NIB_LAST   = 4'(NIBBLES_C - 1);

    present_state_t fsm_q, fsm_d;
    logic [63:0]    state_q, state_d;
    logic [79:0]    kreg_q, kreg_d;
    logic [4:0]     round_q, round_d;
    logic [3:0]     nib_q, nib_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [63:0]    ct_q, ct_d;

    logic [3:0]     sbox_in;
    logic [3:0]     sbox_out;
    logic [79:0]    key_rot;
    logic [5:0]     nib_base;

    assign key_rot  = {kreg_q[18:0], kreg_q[79:19]};
    assign nib_base = {nib_q, 2'b00};

    // The S-box input depends only on FSM state and nibble index, never on its own output.
    always_comb begin
        sbox_in = 4'h0;
        case (fsm_q)
            ST_SUB:  sbox_in = state_q[nib_base +: 4];
            ST_PERM: sbox_in = key_rot[79:76];
            default: sbox_in = 4'h0;
        endcase
    end

    Sbox u_sbox (
        .data_i (sbox_in),
        .data_o (sbox_out)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        fsm_d   = fsm_q;
        state_d = state_q;
        kreg_d  = kreg_q;
        round_d = round_q;
        nib_d   = nib_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ct_d    = ct_q;

        case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = plaintext;
                    kreg_d  = key;
                    round_d = 5'd1;
                    busy_d  = 1'b1;
                    fsm_d   = ST_ADD;
                end
            end
            ST_ADD: begin
                state_d = state_q ^ kreg_q[79:16];
                nib_d   = 4'd0;
                fsm_d   = ST_SUB;
            end
            ST_SUB: begin
                state_d[nib_base +: 4] = sbox_out;
                nib_d                  = nib_q + 4'd1;
                if (nib_q == NIB_LAST) begin
                    fsm_d = ST_PERM;
                end
            end
            ST_PERM: begin
                state_d = p_layer(state_q);
                kreg_d  = {sbox_out, key_rot[75:20], key_rot[19:15] ^ round_q, key_rot[14:0]};
                if (round_q == LAST_ROUND) begin
                    fsm_d = ST_FINAL;
                end else begin
                    round_d = round_q + 5'd1;
                    fsm_d   = ST_ADD;
                end
            end
            ST_FINAL: begin
                ct_d   = state_q ^ kreg_q[79:16];
                done_d = 1'b1;
                busy_d = 1'b0;
                fsm_d  = ST_DONE;
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // Reset clears the datapath too, so an aborted block leaves no key or state behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            kreg_q  <= '0;
            round_q <= '0;
            nib_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ct_q    <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values computed above.
            fsm_q   <= fsm_d;
            state_q <= state_d;
            kreg_q  <= kreg_d;
            round_q <= round_d;
            nib_q   <= nib_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ct_q    <= ct_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ciphertext = ct_q;

endmodule
